regfile_wb_arbiter: RTL and testbench

Arbitrates the single register-file write port between two writeback requesters: port A (ALU/jump result) and port B (load data). Each port has a one-entry holding buffer, so a requester is never blocked combinationally by the other port. The block issues at most one registered write per cycle onto `RegWrite`/`write_reg_addr`/`write_reg_data`, which drive the register file directly. A query port reports whether a register has a write in flight; the pipeline uses it for stall and hazard decisions.

---
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between two writeback sources:
// port A (ALU/jump result) and port B (load data). Each port owns a one-entry
// holding buffer. At most one registered write leaves per cycle. A query port
// reports whether a register still has a write in flight.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg_addr,
  output logic [DATA_W-1:0] write_reg_data,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Holding buffers. The age bit is 1 on the entry that was loaded first;
  // it only matters while both buffers are valid.
  logic              bufa_valid, bufb_valid;
  logic [ADDR_W-1:0] bufa_addr,  bufb_addr;
  logic [DATA_W-1:0] bufa_data,  bufb_data;
  logic              bufa_age,   bufb_age;

  port_e rr_last;
  logic  grant_a, grant_b;
  logic  a_acc, b_acc;
  logic  a_load, b_load;

  // A port can take a new request when its buffer is empty or drains this cycle.
  assign a_ready = reset || !bufa_valid || grant_a;
  assign b_ready = reset || !bufb_valid || grant_b;

  assign a_acc  = a_valid && a_ready && !reset;
  assign b_acc  = b_valid && b_ready && !reset;
  // Writes to register 0 are accepted but never stored.
  assign a_load = a_acc && (a_addr != '0);
  assign b_load = b_acc && (b_addr != '0);

  // Pick at most one buffer: age decides same-register pairs, round-robin otherwise.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (bufa_valid && bufb_valid) begin
      if (bufa_addr == bufb_addr) grant_a = bufa_age;
      else                        grant_a = (rr_last == PORT_B);
      grant_b = !grant_a;
    end else begin
      grant_a = bufa_valid;
      grant_b = bufb_valid;
    end
  end

  // Buffer fill/drain and relative age tracking.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: only the valid/age bits are reset; addr/data are qualified by valid and never observed while it is low.
      bufa_valid <= 1'b0;
      bufb_valid <= 1'b0;
      bufa_age   <= 1'b0;
      bufb_age   <= 1'b0;
    end else begin
      if (a_acc)        bufa_valid <= (a_addr != '0);
      else if (grant_a) bufa_valid <= 1'b0;

      if (b_acc)        bufb_valid <= (b_addr != '0);
      else if (grant_b) bufb_valid <= 1'b0;

      if (a_load) begin
        bufa_addr <= a_addr;
        bufa_data <= a_data;
      end
      if (b_load) begin
        bufb_addr <= b_addr;
        bufb_data <= b_data;
      end

      // A fresh entry is younger than anything held; a same-cycle pair makes A older.
      if (a_load)      bufa_age <= b_load;
      else if (b_load) bufa_age <= 1'b1;

      if (b_load)      bufb_age <= 1'b0;
      else if (a_load) bufb_age <= 1'b1;
    end
  end

  // Registered write port and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      write_reg_addr <= '0;
      write_reg_data <= '0;
      rr_last        <= PORT_B;
    end else if (grant_a) begin
      RegWrite       <= 1'b1;
      write_reg_addr <= bufa_addr;
      write_reg_data <= bufa_data;
      rr_last        <= PORT_A;
    end else if (grant_b) begin
      RegWrite       <= 1'b1;
      write_reg_addr <= bufb_addr;
      write_reg_data <= bufb_data;
      rr_last        <= PORT_B;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Pending-write query; register 0 never reports a hazard.
  assign chk_hit = !reset && (chk_addr != '0) &&
                   ((bufa_valid && bufa_addr == chk_addr) ||
                    (bufb_valid && bufb_addr == chk_addr) ||
                    (RegWrite   && write_reg_addr == chk_addr));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a per-cycle vector table followed by
// hand-written streaming and fairness sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        RegWrite;
  logic [4:0]  write_reg_addr;
  logic [63:0] write_reg_data;
  logic [4:0]  chk_addr;
  logic        chk_hit;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_addr         (a_addr),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_addr         (b_addr),
    .b_data         (b_data),
    .RegWrite       (RegWrite),
    .write_reg_addr (write_reg_addr),
    .write_reg_data (write_reg_data),
    .chk_addr       (chk_addr),
    .chk_hit        (chk_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs driven at the falling edge, outputs expected shortly after.
  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [63:0] bd;
    logic [4:0]  ca;
    logic        ar;
    logic        br;
    logic        rw;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        hit;
  } vec_t;

  localparam int NVEC = 37;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic rst, logic av, logic [4:0] aa, logic [63:0] ad,
                              logic bv, logic [4:0] ba, logic [63:0] bd, logic [4:0] ca,
                              logic ar, logic br, logic rw, logic [4:0] wa,
                              logic [63:0] wd, logic hit);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd; v.ca = ca;
    v.ar = ar; v.br = br; v.rw = rw; v.wa = wa; v.wd = wd; v.hit = hit;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  initial begin
    // rst av aa  ad      bv ba bd     ca   ar br rw wa wd       hit
    // Reset with requests present: nothing may be captured.
    tbl[0]  = mk(1, 1, 5, 64'h99,   1, 6, 64'h98, 5,  1, 1, 0, 0, 64'h0,    0);
    tbl[1]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  5,  1, 1, 0, 0, 64'h0,    0);
    // Contention, different registers, A wins first after reset.
    tbl[2]  = mk(0, 1, 3, 64'd10,   1, 4, 64'd20, 4,  1, 1, 0, 0, 64'h0,    0);
    tbl[3]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  4,  1, 0, 0, 0, 64'h0,    1);
    tbl[4]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  4,  1, 1, 1, 3, 64'd10,   1);
    tbl[5]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  4,  1, 1, 1, 4, 64'd20,   1);
    tbl[6]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  4,  1, 1, 0, 4, 64'd20,   0);
    // Single write, 2-cycle latency, hazard visible for 2 cycles.
    tbl[7]  = mk(0, 1, 5, 64'h1234, 0, 0, 64'h0,  5,  1, 1, 0, 4, 64'd20,   0);
    tbl[8]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  5,  1, 1, 0, 4, 64'd20,   1);
    tbl[9]  = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  5,  1, 1, 1, 5, 64'h1234, 1);
    tbl[10] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  5,  1, 1, 0, 5, 64'h1234, 0);
    // Same register, same cycle, last grant was A: age must still pick A first.
    tbl[11] = mk(0, 1, 7, 64'd1,    1, 7, 64'd2,  7,  1, 1, 0, 5, 64'h1234, 0);
    tbl[12] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 0, 0, 5, 64'h1234, 1);
    tbl[13] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 1, 1, 7, 64'd1,    1);
    tbl[14] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 1, 1, 7, 64'd2,    1);
    tbl[15] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 1, 0, 7, 64'd2,    0);
    // Same register, A in t, B in t+1.
    tbl[16] = mk(0, 1, 7, 64'd1,    0, 0, 64'h0,  7,  1, 1, 0, 7, 64'd2,    0);
    tbl[17] = mk(0, 0, 0, 64'h0,    1, 7, 64'd2,  7,  1, 1, 0, 7, 64'd2,    1);
    tbl[18] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 1, 1, 7, 64'd1,    1);
    tbl[19] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 1, 1, 7, 64'd2,    1);
    tbl[20] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  7,  1, 1, 0, 7, 64'd2,    0);
    // A reloads while B waits; same register, B is now older.
    tbl[21] = mk(0, 1, 3, 64'h31,   1, 9, 64'h91, 9,  1, 1, 0, 7, 64'd2,    0);
    tbl[22] = mk(0, 1, 9, 64'h92,   0, 0, 64'h0,  9,  1, 0, 0, 7, 64'd2,    1);
    tbl[23] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  9,  0, 1, 1, 3, 64'h31,   1);
    tbl[24] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  9,  1, 1, 1, 9, 64'h91,   1);
    tbl[25] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  9,  1, 1, 1, 9, 64'h92,   1);
    tbl[26] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  9,  1, 1, 0, 9, 64'h92,   0);
    // Write to x0: accepted, never issued.
    tbl[27] = mk(0, 0, 0, 64'h0,    1, 0, 64'hFF, 0,  1, 1, 0, 9, 64'h92,   0);
    tbl[28] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0,  1, 1, 0, 9, 64'h92,   0);
    tbl[29] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0,  1, 1, 0, 9, 64'h92,   0);
    tbl[30] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0,  1, 1, 0, 9, 64'h92,   0);
    // Reset while both buffers hold entries and a write is on the port.
    tbl[31] = mk(0, 1, 1, 64'd1,    1, 2, 64'd2,  1,  1, 1, 0, 9, 64'h92,   0);
    tbl[32] = mk(0, 1, 3, 64'd3,    1, 4, 64'd4,  3,  0, 1, 0, 9, 64'h92,   0);
    tbl[33] = mk(1, 1, 3, 64'd3,    1, 4, 64'd4,  4,  1, 1, 1, 2, 64'd2,    0);
    tbl[34] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  4,  1, 1, 0, 0, 64'h0,    0);
    tbl[35] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1,  1, 1, 0, 0, 64'h0,    0);
    tbl[36] = mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1,  1, 1, 0, 0, 64'h0,    0);

    reset = 1'b1;
    chk_addr = '0;
    drive_idle();
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset   = tbl[i].rst;
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      chk_addr = tbl[i].ca;
      #1;
      check($sformatf("v%0d a_ready", i),   64'(a_ready),        64'(tbl[i].ar));
      check($sformatf("v%0d b_ready", i),   64'(b_ready),        64'(tbl[i].br));
      check($sformatf("v%0d RegWrite", i),  64'(RegWrite),       64'(tbl[i].rw));
      check($sformatf("v%0d waddr", i),     64'(write_reg_addr), 64'(tbl[i].wa));
      check($sformatf("v%0d wdata", i),     write_reg_data,      tbl[i].wd);
      check($sformatf("v%0d chk_hit", i),   64'(chk_hit),        64'(tbl[i].hit));
    end

    // Port A streams registers 1..8 back to back with B idle.
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      drive_idle();
      if (cyc < 8) begin
        a_valid = 1'b1;
        a_addr  = 5'(cyc + 1);
        a_data  = 64'(100 + cyc + 1);
      end
      #1;
      check($sformatf("stream c%0d a_ready", cyc), 64'(a_ready), 64'd1);
      if (cyc >= 2 && cyc < 10) begin
        check($sformatf("stream c%0d RegWrite", cyc), 64'(RegWrite), 64'd1);
        check($sformatf("stream c%0d waddr", cyc), 64'(write_reg_addr), 64'(cyc - 1));
        check($sformatf("stream c%0d wdata", cyc), write_reg_data, 64'(100 + cyc - 1));
      end else begin
        check($sformatf("stream c%0d RegWrite", cyc), 64'(RegWrite), 64'd0);
      end
    end

    // Reset pulse so the first contention goes to A.
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    reset = 1'b0;

    // Both ports stream continuously: writes alternate A, B, A, B in order.
    begin
      int a_k = 0;
      int b_k = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
        logic ar_s, br_s;
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'(1 + (a_k % 8));
        a_data  = 64'h A00 + 64'(a_k);
        b_valid = 1'b1;
        b_addr  = 5'(16 + (b_k % 8));
        b_data  = 64'h B00 + 64'(b_k);
        #1;
        ar_s = a_ready;
        br_s = b_ready;
        if (cyc >= 2) begin
          int k;
          k = (cyc - 2) / 2;
          check($sformatf("fair c%0d RegWrite", cyc), 64'(RegWrite), 64'd1);
          if (((cyc - 2) % 2) == 0) begin
            check($sformatf("fair c%0d waddr", cyc), 64'(write_reg_addr), 64'(1 + (k % 8)));
            check($sformatf("fair c%0d wdata", cyc), write_reg_data, 64'h A00 + 64'(k));
          end else begin
            check($sformatf("fair c%0d waddr", cyc), 64'(write_reg_addr), 64'(16 + (k % 8)));
            check($sformatf("fair c%0d wdata", cyc), write_reg_data, 64'h B00 + 64'(k));
          end
        end
        if (ar_s) a_k++;
        if (br_s) b_k++;
      end
    end

    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
